mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store unit between the CPU MEM stage and a data-memory port that may take several cycles to respond.
- Accepts one load or store per request from the pipeline and checks alignment and address range.
- For stores, generates a word-aligned address, byte enables and lane-replicated write data.
- For loads, waits for the memory acknowledge, then extracts, zero-extends or sign-extends the data, and stalls the pipeline until the access completes.

Parameters:
ADDR_LIMIT, 32'h0000_4000, first byte address outside legal data memory (16 KiB = 4096 words)
TIMEOUT, 16, cycles allowed in WAIT before a bus-error completion

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
op_valid  input  1  pipeline presents a memory operation; held until done
op_we  input  1  1 = store, 0 = load
op_ld  input  3  load type: 1 lhu, 2 lh, 3 lbu, 4 lb, 5 lw
op_st  input  2  store type: 1 sh, 2 sb, 3 sw
op_addr  input  32  byte address
op_wdata  input  32  store data, right-justified
stall  output  1  high while op_valid and the access is not yet complete
done  output  1  one-cycle completion pulse
rdata  output  32  extended load result, valid when done
exc_adel  output  1  load address error, valid when done
exc_ades  output  1  store address error, valid when done
exc_bus  output  1  timeout error, valid when done
mem_req  output  1  request to memory
mem_we  output  1  write request
mem_addr  output  32  {addr[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated write data
mem_ack  input  1  memory completes the request this cycle
mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Reset: all registered state and outputs are 0; FSM enters IDLE.
- FSM states: IDLE, REQ, RESP.
- IDLE, op_valid=1, access is illegal:
  - Illegal means half access with addr[0]=1, word access with addr[1:0]!=0, or addr >= ADDR_LIMIT.
  - Go to RESP with exc_adel (load) or exc_ades (store) latched; no mem_req is issued.
- IDLE, op_valid=1, access is legal:
  - Latch we, type, addr, wdata; go to REQ.
  - Latency from op_valid to done is at least 2 cycles.
- REQ:
  - mem_req=1; mem_* outputs are driven from latched registers and stay stable until ack.
  - mem_ack is sampled only while mem_req=1. On ack, latch the extended mem_rdata and go to RESP.
  - The wait counter increments each REQ cycle. When it reaches TIMEOUT-1 without ack: drop mem_req, set exc_bus, go to RESP.
  - A later stray mem_ack is ignored.
- RESP: done=1 for one cycle, rdata and exception flags valid; go to IDLE.
- stall = op_valid & ~done.
- A new op is accepted no earlier than the cycle after RESP (the IDLE cycle).
- Byte enables:
  - sb: be = 1 << addr[1:0].
  - sh: be = addr[1] ? 4'b1100 : 4'b0011.
  - sw: be = 4'b1111.
  - Loads drive be = 4'b1111.
- Write data: sb replicates wdata[7:0] to all 4 lanes; sh replicates wdata[15:0] to both halves; sw passes wdata through.
- Load extraction:
  - Byte lane is addr[1:0]; half lane is addr[1].
  - lbu/lhu zero-extend; lb/lh sign-extend from the selected lane MSB.
  - lw passes the word through.
  - Unknown op_ld values behave as lw.
- Store type 0 is treated as sw.
- rdata is 0 on store or exception completions.
- A $display line "@pc:*addr<=data" is printed on store ack; the memory itself owns the merge of byte-enabled data.
- Synchronous reset asserted mid-REQ: state returns to IDLE and mem_req is 0 after that edge; no done pulse.

Decomposition:
- Package mem_pkg: load codes (LD_HU=1, LD_H=2, LD_BU=3, LD_B=4, LD_W=5), store codes (ST_H=1, ST_B=2, ST_W=3), FSM state encoding.
- Sub-module load_extend: combinational lane select and sign/zero extension. It takes type, addr[1:0] and word, and is reused by the bench as a reference model.

Test Plan:
- sb op_addr=32'h103, op_wdata=32'h0000_00AB, memory ack after 3 cycles -> mem_addr=32'h100, mem_be=4'b1000, mem_wdata=32'hABAB_ABAB, done 1 cycle after ack, stall high until then.
- lb op_addr=32'h202, mem_rdata=32'h0080_1234 -> rdata=32'hFFFF_FF80; lbu at the same address -> 32'h0000_0080; lh at 32'h202 -> 32'h0000_0080.
- lw op_addr=32'h006 -> no mem_req, done with exc_adel=1 two cycles after op_valid; sh at 32'h005 -> exc_ades=1.
- Store to 32'h4000 (>= ADDR_LIMIT) -> exc_ades=1, mem_req never asserted.
- mem_ack withheld -> mem_req drops after 16 REQ cycles, done with exc_bus=1; an ack one cycle later produces no second done.
- reset asserted on the 2nd REQ cycle -> next cycle mem_req=0, done=0, FSM in IDLE; a following sw completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: load/store type codes,
// FSM state encoding and the store lane-steering helpers.
package mem_pkg;

    localparam logic [2:0] LD_HU = 3'd1;
    localparam logic [2:0] LD_H  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd3;
    localparam logic [2:0] LD_B  = 3'd4;
    localparam logic [2:0] LD_W  = 3'd5;

    localparam logic [1:0] ST_H  = 2'd1;
    localparam logic [1:0] ST_B  = 2'd2;
    localparam logic [1:0] ST_W  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Byte enables of a store; type 0 and unknown types behave as a word store.
    function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] lane);
        logic [3:0] be;
        case (st)
            ST_B:    be = 4'b0001 << lane;
            ST_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            ST_W:    be = 4'b1111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the right-justified store data onto every lane it may land in.
    function automatic logic [31:0] store_data(input logic [1:0] st, input logic [31:0] wdata);
        logic [31:0] d;
        case (st)
            ST_B:    d = {4{wdata[7:0]}};
            ST_H:    d = {2{wdata[15:0]}};
            ST_W:    d = wdata;
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Alignment violation: halves need addr[0]=0, words (and unknown codes) addr[1:0]=0.
    function automatic logic misaligned(input logic we, input logic [2:0] ld,
                                        input logic [1:0] st, input logic [1:0] lane);
        logic bad;
        if (we) begin
            case (st)
                ST_B:    bad = 1'b0;
                ST_H:    bad = lane[0];
                default: bad = (lane != 2'b00);
            endcase
        end else begin
            case (ld)
                LD_BU, LD_B: bad = 1'b0;
                LD_HU, LD_H: bad = lane[0];
                default:     bad = (lane != 2'b00);
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load-data extraction: picks the byte/half lane out of the
// memory word and zero- or sign-extends it to 32 bits.
module load_extend
    import mem_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes.
    always_comb begin
        case (lane)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            default: byte_s = word[31:24];
        endcase
        if (lane[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend the selected lane according to the load type; unknown codes act as lw.
    always_comb begin
        case (ld_type)
            LD_BU:   result = {24'h00_0000, byte_s};
            LD_B:    result = {{24{byte_s[7]}}, byte_s};
            LD_HU:   result = {16'h0000, half_s};
            LD_H:    result = {{16{half_s[15]}}, half_s};
            LD_W:    result = word;
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a multi-cycle data-memory port.
// Checks alignment and range, issues one memory request per legal access,
// waits (bounded) for the acknowledge and reports a one-cycle completion.
module mem_access_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_we,
    input  logic [2:0]  op_ld,
    input  logic [1:0]  op_st,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    import mem_pkg::*;

    localparam int          CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_r;
    state_e        state_nx_s;
    logic          we_r;
    logic [2:0]    ld_r;
    logic [31:0]   addr_r;
    logic [3:0]    be_r;
    logic [31:0]   wdata_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   rdata_r;
    logic          exc_adel_r;
    logic          exc_ades_r;
    logic          exc_bus_r;
    logic          illegal_s;
    logic [31:0]   ext_s;

    load_extend u_load_extend (
        .ld_type (ld_r),
        .lane    (addr_r[1:0]),
        .word    (mem_rdata),
        .result  (ext_s)
    );

    // Legality of the operation currently presented by the pipeline.
    always_comb begin
        illegal_s = misaligned(op_we, op_ld, op_st, op_addr[1:0]) | (op_addr >= ADDR_LIMIT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: illegal accesses skip the memory and complete directly.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (op_valid) begin
                    state_nx_s = illegal_s ? S_RESP : S_REQ;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_ack || (cnt_r == CNT_LAST)) begin
                    state_nx_s = S_RESP;
                end else begin
                    state_nx_s = S_REQ;
                end
            end
            S_RESP:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Operation latch, wait counter, load result and exception flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r       <= 1'b0;
            ld_r       <= 3'd0;
            addr_r     <= 32'h0000_0000;
            be_r       <= 4'b0000;
            wdata_r    <= 32'h0000_0000;
            cnt_r      <= '0;
            rdata_r    <= 32'h0000_0000;
            exc_adel_r <= 1'b0;
            exc_ades_r <= 1'b0;
            exc_bus_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    cnt_r      <= '0;
                    rdata_r    <= 32'h0000_0000;
                    exc_bus_r  <= 1'b0;
                    exc_adel_r <= op_valid & illegal_s & ~op_we;
                    exc_ades_r <= op_valid & illegal_s & op_we;
                    if (op_valid) begin
                        we_r    <= op_we;
                        ld_r    <= op_ld;
                        addr_r  <= op_addr;
                        be_r    <= op_we ? store_be(op_st, op_addr[1:0]) : 4'b1111;
                        wdata_r <= op_we ? store_data(op_st, op_wdata) : 32'h0000_0000;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        rdata_r <= we_r ? 32'h0000_0000 : ext_s;
                    end else if (cnt_r == CNT_LAST) begin
                        exc_bus_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_RESP: begin
                    cnt_r <= '0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign done      = (state_r == S_RESP);
    assign mem_req   = (state_r == S_REQ);
    assign stall     = op_valid & ~done;
    assign rdata     = rdata_r;
    assign exc_adel  = exc_adel_r;
    assign exc_ades  = exc_ades_r;
    assign exc_bus   = exc_bus_r;
    assign mem_we    = we_r;
    assign mem_addr  = {addr_r[31:2], 2'b00};
    assign mem_be    = be_r;
    assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed operations, a behavioural
// memory responder and a per-cycle compare against an arithmetic model.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_we;
    logic [2:0]  op_ld;
    logic [1:0]  op_st;
    logic [31:0] op_addr, op_wdata;
    logic        stall, done, exc_adel, exc_ades, exc_bus;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks   = 0;
    int failures = 0;

    // expectations of the operation in flight
    logic        e_we, e_legal;
    logic [2:0]  e_ld;
    logic [1:0]  e_st;
    logic [31:0] e_addr, e_wdata;

    // responder controls
    logic        ack_en = 1'b0, stray_en = 1'b0, prev_req = 1'b0;
    int          ack_delay = 0, req_idx = 0;
    logic [31:0] rd_word = 32'h0;

    // reference extender instance
    logic [2:0]  ref_type;
    logic [1:0]  ref_lane;
    logic [31:0] ref_word, ref_res;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_we(op_we), .op_ld(op_ld),
        .op_st(op_st), .op_addr(op_addr), .op_wdata(op_wdata), .stall(stall), .done(done),
        .rdata(rdata), .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    load_extend u_ref (.ld_type(ref_type), .lane(ref_lane), .word(ref_word), .result(ref_res));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int ld_size(input logic [2:0] t);
        if (t == 3'd3 || t == 3'd4) return 1;
        if (t == 3'd1 || t == 3'd2) return 2;
        return 4;
    endfunction

    function automatic int st_size(input logic [1:0] t);
        if (t == 2'd2) return 1;
        if (t == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic m_legal(input logic we, input logic [2:0] ld, input logic [1:0] st,
                                     input logic [31:0] addr);
        int sz;
        sz = we ? st_size(st) : ld_size(ld);
        return ((addr % sz) == 0) && (addr < 32'h0000_4000);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] addr,
                                           input logic [31:0] word);
        int sz, sh;
        logic [31:0] mask, v;
        sz = ld_size(t);
        if (sz == 4) return word;
        sh   = 8 * int'(addr % 4);
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v    = (word >> sh) & mask;
        if ((t == 3'd2 || t == 3'd4) && (((v >> (8 * sz - 1)) & 32'h1) == 32'h1)) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [1:0] st, input logic [31:0] addr);
        logic [31:0] b;
        if (!we) return 4'b1111;
        b = ((32'h1 << st_size(st)) - 32'h1) << (addr % 4);
        return b[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] st, input logic [31:0] w);
        int sz;
        sz = st_size(st);
        if (sz == 1) return (w & 32'h0000_00FF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'h0000_FFFF) * 32'h0001_0001;
        return w;
    endfunction

    // ---------------- memory responder ----------------
    // Acknowledges after ack_delay request cycles; optionally fires a stray ack
    // in the cycle after the request drops.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdata = rd_word;
            if (mem_req) begin
                mem_ack = ack_en && (req_idx == ack_delay);
                req_idx++;
                if (mem_ack && mem_we) $display("@pc:*%08h<=%08h be=%b", mem_addr, mem_wdata, mem_be);
            end else begin
                mem_ack = stray_en && prev_req;
                req_idx = 0;
            end
            prev_req = mem_req;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic m_busy, m_done_exp, m_done_nx, m_bus;
        int   m_run;
        m_busy = 1'b0; m_done_exp = 1'b0; m_bus = 1'b0; m_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_busy = 1'b0; m_done_exp = 1'b0; m_bus = 1'b0; m_run = 0;
            end else begin
                m_done_nx = 1'b0;
                chk("stall", {31'b0, stall}, {31'b0, op_valid & ~m_done_exp});
                chk("done", {31'b0, done}, {31'b0, m_done_exp});
                if (done) begin
                    chk("exc_adel", {31'b0, exc_adel}, {31'b0, ~e_legal & ~e_we});
                    chk("exc_ades", {31'b0, exc_ades}, {31'b0, ~e_legal & e_we});
                    chk("exc_bus", {31'b0, exc_bus}, {31'b0, m_bus});
                    chk("rdata", rdata, (e_legal && !e_we && !m_bus) ? m_load(e_ld, e_addr, rd_word) : 32'h0);
                end
                if (m_done_exp) begin
                    m_busy = 1'b0;
                end else if (!m_busy && op_valid) begin
                    m_busy = 1'b1;
                    m_bus  = 1'b0;
                    if (!e_legal) m_done_nx = 1'b1;
                end
                if (mem_req) begin
                    m_run++;
                    chk("req_on_illegal", {31'b0, e_legal}, 32'h1);
                    chk("req_overrun", {31'b0, m_run > TIMEOUT}, 32'h0);
                    chk("mem_addr", mem_addr, e_addr & 32'hFFFF_FFFC);
                    chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
                    chk("mem_be", {28'b0, mem_be}, {28'b0, m_be(e_we, e_st, e_addr)});
                    if (e_we) chk("mem_wdata", mem_wdata, m_wdata(e_st, e_wdata));
                    if (mem_ack) m_done_nx = 1'b1;
                    else if (m_run == TIMEOUT) begin m_done_nx = 1'b1; m_bus = 1'b1; end
                end else begin
                    m_run = 0;
                end
                m_done_exp = m_done_nx;
            end
        end
    end

    // Present one operation, wait (bounded) for done and check latency/result.
    task automatic run_op(input logic we, input logic [2:0] ld, input logic [1:0] st,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rword,
                          input int delay, input logic ack_on, input logic stray,
                          input logic [31:0] lit_rd, input int lit_lat, input string name);
        int lat;
        logic got;
        @(posedge clk); #1;
        e_we = we; e_ld = ld; e_st = st; e_addr = addr; e_wdata = wd;
        e_legal = m_legal(we, ld, st, addr);
        rd_word = rword; ack_en = ack_on; ack_delay = delay; stray_en = stray;
        op_we = we; op_ld = ld; op_st = st; op_addr = addr; op_wdata = wd;
        op_valid = 1'b1;
        got = 1'b0; lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin got = 1'b1; break; end
        end
        chk({name, "_done_seen"}, {31'b0, got}, 32'h1);
        if (got) begin
            chk({name, "_latency"}, lat, lit_lat);
            chk({name, "_rdata_lit"}, rdata, lit_rd);
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        stray_en = 1'b0;
        ack_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_ld = 3'd0; op_st = 2'd0;
        op_addr = 32'h0; op_wdata = 32'h0;
        e_we = 1'b0; e_ld = 3'd0; e_st = 2'd0; e_addr = 32'h0; e_wdata = 32'h0; e_legal = 1'b1;

        // model pins against hand-computed values
        chk("pin_lb",   m_load(3'd4, 32'h202, 32'h0080_1234), 32'hFFFF_FF80);
        chk("pin_lbu",  m_load(3'd3, 32'h202, 32'h0080_1234), 32'h0000_0080);
        chk("pin_lh",   m_load(3'd2, 32'h202, 32'h0080_1234), 32'h0000_0080);
        chk("pin_be",   {28'b0, m_be(1'b1, 2'd2, 32'h103)}, 32'h8);
        chk("pin_wd",   m_wdata(2'd2, 32'h0000_00AB), 32'hABAB_ABAB);
        chk("pin_ill",  {31'b0, m_legal(1'b0, 3'd5, 2'd0, 32'h006)}, 32'h0);

        // reference extender against the model on aligned lanes
        ref_word = 32'h80FF_7F01;
        for (int t = 0; t < 8; t++) begin
            for (int l = 0; l < 4; l++) begin
                if ((l % ld_size(3'(t))) == 0) begin
                    ref_type = 3'(t); ref_lane = 2'(l);
                    #1;
                    chk("ref_extend", ref_res, m_load(3'(t), 32'(l), ref_word));
                end
            end
        end

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_be", {28'b0, mem_be}, 32'h0);
        chk("rst_exc", {29'b0, exc_adel, exc_ades, exc_bus}, 32'h0);

        //      we    ld    st    addr          wdata          rword          dly ack stray lit_rd         lat
        run_op(1'b1, 3'd0, 2'd2, 32'h0000_0103, 32'h0000_00AB, 32'h0,         3, 1'b1, 1'b0, 32'h0,         6, "sb");
        run_op(1'b0, 3'd4, 2'd0, 32'h0000_0202, 32'h0,         32'h0080_1234, 0, 1'b1, 1'b0, 32'hFFFF_FF80, 3, "lb");
        run_op(1'b0, 3'd3, 2'd0, 32'h0000_0202, 32'h0,         32'h0080_1234, 1, 1'b1, 1'b0, 32'h0000_0080, 4, "lbu");
        run_op(1'b0, 3'd2, 2'd0, 32'h0000_0202, 32'h0,         32'h0080_1234, 0, 1'b1, 1'b0, 32'h0000_0080, 3, "lh");
        run_op(1'b0, 3'd1, 2'd0, 32'h0000_0206, 32'h0,         32'h8001_0000, 2, 1'b1, 1'b0, 32'h0000_8001, 5, "lhu");
        run_op(1'b0, 3'd2, 2'd0, 32'h0000_0206, 32'h0,         32'h8001_0000, 0, 1'b1, 1'b0, 32'hFFFF_8001, 3, "lh_neg");
        run_op(1'b0, 3'd4, 2'd0, 32'h0000_0003, 32'h0,         32'h7F00_0000, 0, 1'b1, 1'b0, 32'h0000_007F, 3, "lb_pos");
        run_op(1'b0, 3'd5, 2'd0, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 4, "lw");
        run_op(1'b0, 3'd7, 2'd0, 32'h0000_0030, 32'h0,         32'h8000_00F1, 0, 1'b1, 1'b0, 32'h8000_00F1, 3, "ld_unknown");
        run_op(1'b1, 3'd0, 2'd1, 32'h0000_0102, 32'h1234_CDEF, 32'h0,         0, 1'b1, 1'b0, 32'h0,         3, "sh");
        run_op(1'b1, 3'd0, 2'd0, 32'h0000_0034, 32'hCAFE_F00D, 32'h0,         1, 1'b1, 1'b0, 32'h0,         4, "st0_as_sw");
        run_op(1'b0, 3'd5, 2'd0, 32'h0000_0006, 32'h0,         32'h1111_1111, 0, 1'b1, 1'b0, 32'h0,         2, "lw_misalign");
        run_op(1'b1, 3'd0, 2'd1, 32'h0000_0005, 32'h0000_5555, 32'h0,         0, 1'b1, 1'b0, 32'h0,         2, "sh_misalign");
        run_op(1'b1, 3'd0, 2'd3, 32'h0000_4000, 32'h0000_0001, 32'h0,         0, 1'b1, 1'b0, 32'h0,         2, "sw_range");
        run_op(1'b0, 3'd4, 2'd0, 32'h0000_4000, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 1'b0, 32'h0,         2, "lb_range");
        run_op(1'b0, 3'd5, 2'd0, 32'h0000_0010, 32'h0,         32'h2222_2222, 0, 1'b0, 1'b1, 32'h0,        18, "timeout");
        run_op(1'b1, 3'd0, 2'd3, 32'h0000_3FFC, 32'h0BAD_CAFE, 32'h0,         0, 1'b1, 1'b0, 32'h0,         3, "sw_last");

        // reset on the second request cycle
        @(posedge clk); #1;
        e_we = 1'b1; e_ld = 3'd0; e_st = 2'd3; e_addr = 32'h20; e_wdata = 32'h1234_5678;
        e_legal = 1'b1; ack_en = 1'b0;
        op_we = 1'b1; op_st = 2'd3; op_addr = 32'h20; op_wdata = 32'h1234_5678; op_valid = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid_req_active", {31'b0, mem_req}, 32'h1);
        reset = 1'b1; op_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", {31'b0, mem_req}, 32'h0);
        chk("mid_rst_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        chk("mid_rst_done2", {31'b0, done}, 32'h0);

        run_op(1'b1, 3'd0, 2'd3, 32'h0000_0020, 32'h1234_5678, 32'h0,         2, 1'b1, 1'b0, 32'h0,         5, "sw_after_rst");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
